bit_pattern_tx: RTL
===================

// Module: bit_pattern_tx
// PURPOSE
//  Serial bit-pattern transmitter: the sending end of the single-bit stream consumed by the
//  lab sequence-detector FSMs. Latches a WIDTH-bit pattern plus a repeat count on start, then
//  shifts it out MSB-first, one bit per enabled cycle. Emits a 1-cycle done pulse after the last
//  bit. Sits between the testbench/top-level stimulus logic and a detector's serial input.
// PARAMETERS
//  WIDTH   8   pattern length in bits (>=2)
//  CNT_W   4   width of repeat count; total transmissions = rep+1 (1..2^CNT_W)
// PORTS
//  clk        in   1       system clock, rising-edge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       request; sampled only in IDLE
//  data       in   WIDTH   pattern, latched on accepted start
//  rep        in   CNT_W   extra repetitions, latched on accepted start
//  en         in   1       step enable; 0 = stall (hold current bit)
//  bit_out    out  1       current serial bit
//  bit_valid  out  1       bit_out is meaningful this cycle
//  busy       out  1       high in SHIFT state
//  done       out  1       1-cycle pulse after final bit consumed
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; bit_out=0, bit_valid=0, busy=0, done=0; shift reg,
//    bit counter, repeat counter cleared. Reset mid-transfer aborts; no done pulse.
//  - States: IDLE -> SHIFT -> DONE -> IDLE (binary encoding, 2 bits).
//  - IDLE: start=1 at edge t latches data/rep, loads bit counter = WIDTH-1 -> SHIFT at t+1.
//  - SHIFT: bit_valid=1, busy=1, bit_out = shreg[WIDTH-1]. A bit is consumed at an edge where
//    en=1. On consume: if bitcnt!=0, shift left by 1, bitcnt--. If bitcnt==0 and repcnt!=0:
//    reload latched pattern, bitcnt=WIDTH-1, repcnt-- (no gap cycle between repetitions).
//    If bitcnt==0 and repcnt==0 -> DONE.
//  - en=0 in SHIFT: all registers hold; bit_out/bit_valid unchanged.
//  - DONE: done=1, busy=0, bit_valid=0, bit_out=0 for exactly one cycle -> IDLE unconditionally.
//  - start outside IDLE (SHIFT or DONE) ignored; data/rep changes after latch have no effect.
//  - Latency: start at edge t, en held 1 -> first bit valid in cycle t+1, last bit in cycle
//    t+WIDTH*(rep+1), done in cycle t+WIDTH*(rep+1)+1.
//  - Counter widths: bitcnt = $clog2(WIDTH) bits; repcnt = CNT_W bits, decrements, no wrap
//    (rep = 2^CNT_W-1 gives 2^CNT_W transmissions).
//  - All outputs registered (Moore); no combinational path from inputs to outputs.
// STRUCTURE
//  - bit_pattern_defs.vh: state localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
//  - Two always blocks in top: state register (async reset) + next-state/output logic.
//  - One sub-module: bit_pattern_shreg (WIDTH shift reg with load/shift/hold, async reset,
//    MSB output) instantiated once; counters stay in top.
// TESTING (WIDTH=8, CNT_W=4)
//  1. data=8'hB2, rep=0, en=1, start 1 cycle -> bit_out 1,0,1,1,0,0,1,0 cycles 1..8,
//     bit_valid=1 cycles 1..8, done=1 cycle 9 only, busy low cycle 9.
//  2. data=8'h81, rep=2, en=1 -> 24 back-to-back bits (1000_0001 x3), no gap, done cycle 25.
//  3. data=8'hB2, rep=0, en=0 in cycles 3-4 -> bit_out stays 1 (3rd bit) cycles 3-5, stream
//     resumes 1,0,0,1,0, done in cycle 11.
//  4. start pulsed again in cycle 4 with data=8'hFF and in done cycle -> ignored; stream is
//     still 8'hB2; IDLE after done, next start accepted normally.
//  5. reset asserted mid-cycle during bit 4 -> bit_valid/busy drop to 0 before next edge,
//     no done pulse; post-reset start with 8'h0F sends 0000_1111 cleanly.
//  6. rep=4'hF, data=8'h01 -> 128 valid bits, exactly 16 ones, done cycle 129.

Source files
------------

// File: rtl/bit_pattern_tx_pkg.sv
// Shared definitions for the serial bit-pattern transmitter.
package bit_pattern_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_pattern_shreg.sv
// Pattern shift register: parallel load, shift left by one, or hold; MSB is the serial bit.
module bit_pattern_shreg
  import bit_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sh_r;

  // load has priority over shift so a repetition reload never loses a cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sh_r <= din;
    end else if (shift) begin
      sh_r <= {sh_r[WIDTH-2:0], 1'b0};
    end else begin
      sh_r <= sh_r;
    end
  end

  assign msb = sh_r[WIDTH-1];

endmodule

// File: rtl/bit_pattern_tx.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first rep+1 times, then pulses done.
module bit_pattern_tx
  import bit_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] rep,
  input  logic             en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_e           state_r, state_s;
  logic [BW-1:0]    bitcnt_r, bitcnt_s;
  logic [CNT_W-1:0] repcnt_r, repcnt_s;
  logic [WIDTH-1:0] pattern_r, pattern_s;
  logic             load_s, shift_s, msb_s;
  logic [WIDTH-1:0] load_data_s;

  bit_pattern_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .shift (shift_s),
    .din   (load_data_s),
    .msb   (msb_s)
  );

  // state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      bitcnt_r  <= {BW{1'b0}};
      repcnt_r  <= {CNT_W{1'b0}};
      pattern_r <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      bitcnt_r  <= bitcnt_s;
      repcnt_r  <= repcnt_s;
      pattern_r <= pattern_s;
    end
  end

  // next-state, counter update and shift-register control
  always_comb begin
    state_s     = state_r;
    bitcnt_s    = bitcnt_r;
    repcnt_s    = repcnt_r;
    pattern_s   = pattern_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    load_data_s = pattern_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s     = S_SHIFT;
          pattern_s   = data;
          repcnt_s    = rep;
          bitcnt_s    = BIT_LAST;
          load_s      = 1'b1;
          load_data_s = data;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (!en) begin
          state_s = S_SHIFT;
        end else if (bitcnt_r != {BW{1'b0}}) begin
          shift_s  = 1'b1;
          bitcnt_s = bitcnt_r - BW'(1);
        end else if (repcnt_r != {CNT_W{1'b0}}) begin
          // back-to-back repetition: reload from the latched copy, no idle gap
          load_s   = 1'b1;
          bitcnt_s = BIT_LAST;
          repcnt_s = repcnt_r - CNT_W'(1);
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state and the shift-register MSB
  always_comb begin
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_r)
      S_SHIFT: begin
        bit_out   = msb_s;
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: done = 1'b0;
    endcase
  end

endmodule
